lcm_feeder: RTL and testbench

Operand sequencer placed directly upstream of the LCM processor core. It buffers a stream of 8-bit operands grouped into lists, and drives the core's `go_i`/`x_i`/`y_i` pair-by-pair, feeding each partial result back as the next `x`. It returns the LCM of the whole list on a valid/ready result port. This turns the two-operand core into a list-LCM engine without modifying the core.

---
 rtl/lcm_feeder.sv | 185 ++++++++++++++++++
 tb/tb_lcm_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_feeder.sv
// List-LCM sequencer in front of a two-operand LCM core: buffers {last,data}
// operands, chains partial results back through the core. Optional watchdog: LCM_FEEDER_TIMEOUT_EN.
module lcm_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       go_o,
  input  logic       core_done_i,
  input  logic [7:0] core_d_i,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_err,
  input  logic       res_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_OUT
  } state_t;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        rdy_q;
  logic        empty, full, push, pop;
  logic [7:0]  head_data;
  logic        head_last;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        go_q, go_d;
  logic        done_ok;
  logic        timeout;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // rdy_q keeps in_ready low while reset is applied, independent of pointer state
  assign in_ready  = rdy_q & ~full;
  assign push      = in_valid & in_ready;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]][7:0];
  assign head_last = mem_q[rd_ptr_q[AW-1:0]][8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
  end

`ifdef LCM_FEEDER_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Counter is zero whenever the FSM is outside WAIT, so each WAIT starts fresh.
  always_comb wdog_d = (state_q == S_WAIT) ? wdog_q + 8'd1 : '0;

  always_ff @(posedge clk) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end

  assign timeout = (state_q == S_WAIT) && (wdog_q == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  // A done pulse in the go cycle itself is too early to belong to this issue.
  assign done_ok = core_done_i & ~go_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      last_q  <= last_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    last_d  = last_q;
    go_d    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_FIRST;
      end
      S_FIRST: begin
        pop   = 1'b1;
        acc_d = head_data;
        if (head_data == '0) err_d = 1'b1;
        if (head_last)            state_d = S_OUT;
        else if (head_data == '0) state_d = S_DRAIN;
        else                      state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!empty) begin
          pop    = 1'b1;
          last_d = head_last;
          if (head_data == '0) begin
            err_d   = 1'b1;
            acc_d   = '0;
            state_d = head_last ? S_OUT : S_DRAIN;
          end else begin
            x_d     = acc_q;
            y_d     = head_data;
            go_d    = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (done_ok) begin
          acc_d   = core_d_i;
          state_d = last_q ? S_OUT : S_ISSUE;
        end else if (timeout) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = last_q ? S_OUT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign go_o      = go_q;
  assign res_valid = (state_q == S_OUT);
  assign res_data  = acc_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_lcm_feeder.sv
// Bench for lcm_feeder: behavioural LCM core, vector table of lists, result scoreboard.
module tb_lcm_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] x_o, y_o;
  logic       go_o;
  logic       core_done_i;
  logic [7:0] core_d_i;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_err;
  logic       res_ready;

  lcm_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .x_o(x_o), .y_o(y_o), .go_o(go_o),
    .core_done_i(core_done_i), .core_d_i(core_d_i),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gos = 0;
  logic [7:0] gx = '0, gy = '0;
  int cnt = 0;
  bit hold_core = 1'b0;
  bit core_kill = 1'b0;
  logic [8:0] sb [$];

  typedef struct {
    int             n;
    logic [2:0][7:0] ops;
    logic [7:0]     exp_d;
    bit             exp_e;
    int             exp_gos;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lcm8(input logic [7:0] a, input logic [7:0] b);
    int unsigned p, q, t;
    p = a; q = b;
    while (q != 0) begin t = p % q; p = q; q = t; end
    if (p == 0) return 8'd0;
    return 8'((32'(a) * 32'(b)) / p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural core: result three cycles after go, operands must stay put meanwhile.
  always @(negedge clk) begin
    if (!rst || core_kill) begin
      core_done_i = 1'b0;
      cnt = 0;
    end else begin
      core_done_i = 1'b0;
      if (cnt != 0) begin
        check("x_hold", x_o, gx);
        check("y_hold", y_o, gy);
        if (!(hold_core && cnt == 1)) begin
          cnt--;
          if (cnt == 0) begin
            core_done_i = 1'b1;
            core_d_i = lcm8(gx, gy);
          end
        end
      end
      if (go_o) begin
        gx = x_o; gy = y_o; cnt = 3; gos++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {23'd0, res_err, res_data}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("result", {23'd0, res_err, res_data}, {23'd0, e});
      end
    end
  end

  task automatic push_op(input logic [7:0] d, input bit l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 1000) begin tick(); t++; end
    if (!in_ready) check("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_sb();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin tick(); t++; end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_list(input int n, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] ed, input bit ee, input int eg);
    int g0;
    logic [2:0][7:0] ops;
    ops = {c, b, a};
    g0 = gos;
    sb.push_back({ee, ed});
    for (int k = 0; k < n; k++) push_op(ops[k], k == n - 1);
    wait_sb();
    check("go_count", gos - g0, eg);
  endtask

  task automatic setv(input int i, input int n, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d, input bit e, input int g);
    vt[i].n = n; vt[i].ops = {c, b, a};
    vt[i].exp_d = d; vt[i].exp_e = e; vt[i].exp_gos = g;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    setv(0,  2, 4,  6,  0,  12,  0, 1);
    setv(1,  3, 4,  6,  10, 60,  0, 2);
    setv(2,  1, 7,  0,  0,  7,   0, 0);
    setv(3,  2, 9,  3,  0,  9,   0, 1);
    setv(4,  3, 3,  0,  5,  0,   1, 0);
    setv(5,  2, 2,  5,  0,  10,  0, 1);
    setv(6,  2, 0,  5,  0,  0,   1, 0);
    setv(7,  1, 0,  0,  0,  0,   1, 0);
    setv(8,  3, 15, 20, 6,  60,  0, 2);
    setv(9,  2, 16, 17, 0,  16,  0, 1);
    setv(10, 2, 5,  0,  0,  0,   1, 0);

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b1;
    core_done_i = 1'b0; core_d_i = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_go", go_o, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_x", x_o, 0);
    check("rst_y", y_o, 0);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      run_list(vt[i].n, vt[i].ops[0], vt[i].ops[1], vt[i].ops[2],
               vt[i].exp_d, vt[i].exp_e, vt[i].exp_gos);
      if (i == 0) begin
        check("go0_x", gx, 4);
        check("go0_y", gy, 6);
      end
      if (i == 1) begin
        check("go1_x", gx, 12);
        check("go1_y", gy, 10);
      end
    end

    // Core stalled: FIFO fills behind the stuck WAIT and in_ready must fall.
    begin
      int g0;
      g0 = gos;
      hold_core = 1'b1;
      sb.push_back({1'b0, 8'd164});
      for (int k = 2; k <= 7; k++) push_op(8'(k), k == 7);
      repeat (3) tick();
      check("full_in_ready", in_ready, 0);
      check("full_no_result", res_valid, 0);
      hold_core = 1'b0;
      wait_sb();
      check("full_go_count", gos - g0, 5);
      check("drained_in_ready", in_ready, 1);
    end

    // Result held while consumer stalls.
    begin
      int t = 0;
      res_ready = 1'b0;
      sb.push_back({1'b0, 8'd12});
      push_op(8'd4, 1'b0);
      push_op(8'd6, 1'b1);
      while (!res_valid && t < 200) begin tick(); t++; end
      for (int k = 0; k < 10; k++) begin
        tick();
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, 12);
      end
      res_ready = 1'b1;
      wait_sb();
    end

    // Reset in the middle of WAIT abandons the list.
    begin
      int g0, t;
      g0 = gos; t = 0;
      push_op(8'd4, 1'b0);
      push_op(8'd6, 1'b1);
      while (gos == g0 && t < 50) begin tick(); t++; end
      check("midrst_go_seen", gos - g0, 1);
      tick();
      rst = 1'b0;
      tick();
      check("midrst_in_ready", in_ready, 0);
      check("midrst_go", go_o, 0);
      check("midrst_valid", res_valid, 0);
      check("midrst_data", res_data, 0);
      check("midrst_err", res_err, 0);
      check("midrst_x", x_o, 0);
      check("midrst_y", y_o, 0);
      rst = 1'b1;
      tick();
      check("midrst_rel_ready", in_ready, 1);
      repeat (10) tick();
      check("midrst_no_result", res_valid, 0);
      check("midrst_no_go", gos - g0, 1);
      run_list(2, 8'd8, 8'd12, 8'd0, 8'd24, 1'b0, 1);
    end

`ifdef LCM_FEEDER_TIMEOUT_EN
    hold_core = 1'b1;
    run_list(2, 8'd4, 8'd6, 8'd0, 8'd0, 1'b1, 1);
    core_kill = 1'b1; tick(); core_kill = 1'b0;
    run_list(3, 8'd4, 8'd6, 8'd10, 8'd0, 1'b1, 1);
    core_kill = 1'b1; tick(); core_kill = 1'b0;
    hold_core = 1'b0;
    run_list(2, 8'd3, 8'd4, 8'd0, 8'd12, 1'b0, 1);
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
